// File: rtl/dense_25d_pkg.sv
// dense_25d_pkg
// Shared helpers for the 2.5D dense layer slice:
//   clog2        - ceiling log2 of a positive integer (clog2(1) = 0)
//   calc_lat     - edges from the completing accept to pixel_valid_out
//   kernel_index - bit offset of weight (z,t,i) inside the flat kernel bus
//   tree_index   - bit offset of tree t inside the flat bias / output buses
package dense_25d_pkg;

  function automatic int clog2(input int value);
    int result;
    int remaining;
    result = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // One multiply stage, one adder level per tap halving, one adder level per
  // channel halving, and the bias/ReLU output register.
  function automatic int calc_lat(input int ma_tree_size, input int z_depth);
    return 2 + clog2(ma_tree_size) + clog2(z_depth);
  endfunction

  function automatic int kernel_index(input int z, input int t, input int i,
                                      input int num_trees, input int ma_tree_size,
                                      input int kernel_w);
    return ((z * num_trees + t) * ma_tree_size + i) * kernel_w;
  endfunction

  function automatic int tree_index(input int t, input int acc_w);
    return t * acc_w;
  endfunction

endpackage

// File: rtl/dense_25d_mac_tree.sv
// dense_25d_mac_tree
// One pipelined multiply-adder tree: MA_TREE_SIZE unsigned pixels times
// MA_TREE_SIZE signed weights, summed into a wrapping ACC_W result.
// Latency is 1 + clog2(MA_TREE_SIZE) edges; the tree free-runs every cycle
// and validity is tracked by the caller.
// Ports:
//   clock   - rising-edge clock
//   reset   - asynchronous, active-low; clears every pipeline register
//   pixels  - tap i at [i*PIXEL_W +: PIXEL_W], zero-extended
//   weights - tap i at [i*KERNEL_W +: KERNEL_W], sign-extended
//   sum     - registered dot product of the taps
module dense_25d_mac_tree
  import dense_25d_pkg::*;
#(
  parameter int PIXEL_W      = 8,
  parameter int KERNEL_W     = 8,
  parameter int ACC_W        = 32,
  parameter int MA_TREE_SIZE = 16
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [MA_TREE_SIZE*PIXEL_W-1:0]  pixels,
  input  logic [MA_TREE_SIZE*KERNEL_W-1:0] weights,
  output logic signed [ACC_W-1:0]          sum
);

  // Heap-ordered tree: node k has children 2k+1 and 2k+2, and the leaves
  // (the registered products) sit at MA_TREE_SIZE-1 .. 2*MA_TREE_SIZE-2.
  // Because the tap count is a power of two every leaf is at the same depth,
  // so registering every node keeps all partial sums time-aligned.
  localparam int NODES = 2 * MA_TREE_SIZE - 1;

  logic signed [ACC_W-1:0] product [MA_TREE_SIZE];
  logic signed [ACC_W-1:0] node    [NODES];

  // Both operands are widened to ACC_W first, so the low ACC_W bits of the
  // product are exact and any overflow wraps like the rest of the datapath.
  always_comb begin
    for (int i = 0; i < MA_TREE_SIZE; i++) begin
      product[i] = $signed(ACC_W'({1'b0, pixels[i*PIXEL_W +: PIXEL_W]}))
                 * ACC_W'($signed(weights[i*KERNEL_W +: KERNEL_W]));
    end
  end

  // Multiply stage into the leaves plus one adder level per tree depth.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NODES; k++) begin
        node[k] <= '0;
      end
    end else begin
      for (int k = 0; k < MA_TREE_SIZE - 1; k++) begin
        node[k] <= node[2*k+1] + node[2*k+2];
      end
      for (int i = 0; i < MA_TREE_SIZE; i++) begin
        node[MA_TREE_SIZE-1+i] <= product[i];
      end
    end
  end

  assign sum = node[0];

endmodule

// File: rtl/dense_25d_stream.sv
// dense_25d_stream
// Valid-qualified 2.5D dense layer. Keeps a sliding window of the last
// MA_TREE_SIZE accepted pixels per Z channel, computes NUM_TREES dot
// products per channel with pipelined MAC trees, reduces across channels,
// then adds a per-tree bias and optionally clamps negatives to zero.
// Results are produced only for completely filled windows.
// Ports:
//   clock, reset      - rising-edge clock, asynchronous active-low reset
//   clear             - synchronous flush of fill count and in-flight valids
//   pixel_valid_in    - qualifies pixel_vector_in (dropped when clear is high)
//   pixel_vector_in   - channel z at [z*PIXEL_W +: PIXEL_W]
//   kernel            - weight (z,t,i) at kernel_index(z,t,i,...)
//   bias              - signed bias for tree t at [t*ACC_W +: ACC_W]
//   relu_en           - clamp negative results to 0
//   pixel_valid_out   - one-cycle qualifier per result
//   pixel_vector_out  - tree t at [t*ACC_W +: ACC_W], held between results
module dense_25d_stream
  import dense_25d_pkg::*;
#(
  parameter int PIXEL_W      = 8,
  parameter int KERNEL_W     = 8,
  parameter int ACC_W        = 32,
  parameter int NUM_TREES    = 2,
  parameter int Z_DEPTH      = 4,
  parameter int MA_TREE_SIZE = 16
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic                                             clear,
  input  logic                                             pixel_valid_in,
  input  logic [Z_DEPTH*PIXEL_W-1:0]                       pixel_vector_in,
  input  logic [NUM_TREES*Z_DEPTH*MA_TREE_SIZE*KERNEL_W-1:0] kernel,
  input  logic [NUM_TREES*ACC_W-1:0]                       bias,
  input  logic                                             relu_en,
  output logic                                             pixel_valid_out,
  output logic [NUM_TREES*ACC_W-1:0]                       pixel_vector_out
);

  localparam int LAT      = calc_lat(MA_TREE_SIZE, Z_DEPTH);
  localparam int CNT_W    = clog2(MA_TREE_SIZE) + 1;
  localparam int Z_LEVELS = clog2(Z_DEPTH);
  localparam int Z_PAD    = 1 << Z_LEVELS;
  localparam int WIN_W    = MA_TREE_SIZE * PIXEL_W;

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(MA_TREE_SIZE);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(MA_TREE_SIZE - 1);

  logic                    accept;
  logic                    complete;
  logic                    post_fire;
  logic [CNT_W-1:0]        fill_count;
  logic [WIN_W-1:0]        window      [Z_DEPTH];
  logic [LAT-1:0]          token;
  logic signed [ACC_W-1:0] z_sum       [NUM_TREES];
  logic signed [ACC_W-1:0] post_result [NUM_TREES];

  // clear beats a simultaneous valid, so the sample never reaches the window.
  assign accept   = pixel_valid_in && !clear;
  assign complete = accept && ((fill_count == LAST_COUNT) || (fill_count == FULL_COUNT));

  // Per-channel window: the newest pixel enters at the top tap and tap 0
  // (the oldest) falls off the bottom. clear leaves the data alone because
  // a refill always overwrites every tap before the next valid result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int z = 0; z < Z_DEPTH; z++) begin
        window[z] <= '0;
      end
    end else if (accept) begin
      for (int z = 0; z < Z_DEPTH; z++) begin
        window[z] <= {pixel_vector_in[z*PIXEL_W +: PIXEL_W], window[z][WIN_W-1:PIXEL_W]};
      end
    end
  end

  // Fill count saturates at the window size so every later accept is a
  // complete window.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fill_count <= '0;
    end else if (clear) begin
      fill_count <= '0;
    end else if (accept && (fill_count != FULL_COUNT)) begin
      fill_count <= fill_count + CNT_W'(1);
    end
  end

  // Valid tokens travel alongside the free-running datapath; token[k] is
  // set k edges after the completing accept.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      token <= '0;
    end else if (clear) begin
      token <= '0;
    end else begin
      token <= {token[LAT-2:0], complete};
    end
  end

  for (genvar t = 0; t < NUM_TREES; t++) begin : g_tree
    logic signed [ACC_W-1:0] z_leaf [Z_PAD];

    // Channels beyond Z_DEPTH are padded with zero so the channel tree is
    // always a full power of two and every path has the same depth.
    for (genvar z = 0; z < Z_PAD; z++) begin : g_chan
      if (z < Z_DEPTH) begin : g_mac
        logic signed [ACC_W-1:0] mac_sum;

        dense_25d_mac_tree #(
          .PIXEL_W      (PIXEL_W),
          .KERNEL_W     (KERNEL_W),
          .ACC_W        (ACC_W),
          .MA_TREE_SIZE (MA_TREE_SIZE)
        ) u_mac (
          .clock   (clock),
          .reset   (reset),
          .pixels  (window[z]),
          .weights (kernel[kernel_index(z, t, 0, NUM_TREES, MA_TREE_SIZE, KERNEL_W) +: MA_TREE_SIZE*KERNEL_W]),
          .sum     (mac_sum)
        );

        assign z_leaf[z] = mac_sum;
      end else begin : g_pad
        assign z_leaf[z] = '0;
      end
    end

    if (Z_LEVELS == 0) begin : g_no_z_tree
      assign z_sum[t] = z_leaf[0];
    end else begin : g_z_tree
      // Registered channel-reduction nodes in heap order; the MAC outputs
      // act as the (already registered) leaves.
      logic signed [ACC_W-1:0] z_node [Z_PAD-1];

      for (genvar k = 0; k < Z_PAD - 1; k++) begin : g_node
        if (2*k + 1 >= Z_PAD - 1) begin : g_leaf_pair
          always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
              z_node[k] <= '0;
            end else begin
              z_node[k] <= z_leaf[2*k+1-(Z_PAD-1)] + z_leaf[2*k+2-(Z_PAD-1)];
            end
          end
        end else begin : g_inner
          always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
              z_node[k] <= '0;
            end else begin
              z_node[k] <= z_node[2*k+1] + z_node[2*k+2];
            end
          end
        end
      end

      assign z_sum[t] = z_node[0];
    end

    assign post_result[t] = z_sum[t] + $signed(bias[tree_index(t, ACC_W) +: ACC_W]);
  end

  // A token leaving the pipeline on the same edge as clear is also dropped.
  assign post_fire = token[LAT-1] && !clear;

  // Bias/ReLU stage: the output bus only moves when a result is emitted, so
  // it holds the previous result while pixel_valid_out is low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pixel_valid_out  <= 1'b0;
      pixel_vector_out <= '0;
    end else begin
      pixel_valid_out <= post_fire;
      if (post_fire) begin
        for (int t = 0; t < NUM_TREES; t++) begin
          pixel_vector_out[tree_index(t, ACC_W) +: ACC_W] <=
            (relu_en && post_result[t][ACC_W-1]) ? '0 : post_result[t];
        end
      end
    end
  end

endmodule

// File: tb/tb_dense_25d_stream.sv
// tb_dense_25d_stream
// Directed bench for dense_25d_stream at its default parameters. Pixels are
// a counter on all four channels, so a complete window ending at sample n
// sums to 4 * (16n - 120) per unit weight: 480 at n=15, 544 at n=16.
module tb_dense_25d_stream;

  localparam int PIXEL_W   = 8;
  localparam int KERNEL_W  = 8;
  localparam int ACC_W     = 32;
  localparam int NUM_TREES = 2;
  localparam int Z_DEPTH   = 4;
  localparam int MA        = 16;

  typedef struct {
    logic [7:0]  w0;
    logic [7:0]  w1;
    logic [31:0] b0;
    logic [31:0] b1;
    logic        relu;
    logic [31:0] first0;
    logic [31:0] first1;
    logic [31:0] second0;
    logic [31:0] second1;
  } vec_t;

  logic                                     clock;
  logic                                     reset;
  logic                                     clear;
  logic                                     pixel_valid_in;
  logic [Z_DEPTH*PIXEL_W-1:0]               pixel_vector_in;
  logic [NUM_TREES*Z_DEPTH*MA*KERNEL_W-1:0] kernel;
  logic [NUM_TREES*ACC_W-1:0]               bias;
  logic                                     relu_en;
  logic                                     pixel_valid_out;
  logic [NUM_TREES*ACC_W-1:0]               pixel_vector_out;

  int   compared;
  int   mismatched;
  vec_t tbl [6];

  dense_25d_stream #(
    .PIXEL_W      (PIXEL_W),
    .KERNEL_W     (KERNEL_W),
    .ACC_W        (ACC_W),
    .NUM_TREES    (NUM_TREES),
    .Z_DEPTH      (Z_DEPTH),
    .MA_TREE_SIZE (MA)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .clear            (clear),
    .pixel_valid_in   (pixel_valid_in),
    .pixel_vector_in  (pixel_vector_in),
    .kernel           (kernel),
    .bias             (bias),
    .relu_en          (relu_en),
    .pixel_valid_out  (pixel_valid_out),
    .pixel_vector_out (pixel_vector_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Drive one cycle of inputs, then observe 1 time unit after the edge.
  task automatic applyStimulus(input logic valid, input int sample, input logic clr);
    logic [7:0] pix;
    pix             = sample[7:0];
    pixel_valid_in  = valid;
    pixel_vector_in = {4{pix}};
    clear           = clr;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic exp_valid,
                             input logic [31:0] exp0, input logic [31:0] exp1);
    compared++;
    if (pixel_valid_out !== exp_valid) begin
      mismatched++;
      $display("[TB] FAIL %s valid: got %0b want %0b", name, pixel_valid_out, exp_valid);
    end
    compared++;
    if (pixel_vector_out !== {exp1, exp0}) begin
      mismatched++;
      $display("[TB] FAIL %s data: got t0=%0d t1=%0d want t0=%0d t1=%0d", name,
               $signed(pixel_vector_out[31:0]), $signed(pixel_vector_out[63:32]),
               $signed(exp0), $signed(exp1));
    end
  endtask

  task automatic configure(input logic [7:0] w0, input logic [7:0] w1,
                           input logic [31:0] b0, input logic [31:0] b1, input logic relu);
    for (int z = 0; z < Z_DEPTH; z++) begin
      for (int t = 0; t < NUM_TREES; t++) begin
        for (int i = 0; i < MA; i++) begin
          kernel[((z*NUM_TREES+t)*MA+i)*KERNEL_W +: KERNEL_W] = (t == 0) ? w0 : w1;
        end
      end
    end
    bias    = {b1, b0};
    relu_en = relu;
  endtask

  task automatic doReset();
    reset          = 1'b0;
    pixel_valid_in = 1'b0;
    clear          = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;
    checkOutput("reset_state", 1'b0, 32'd0, 32'd0);
  endtask

  // Samples 0..16 accepted on edges 0..16; results for samples 15 and 16
  // appear on edges 23 and 24, and the bus holds afterwards.
  task automatic runStream(input int idx, input logic with_reset);
    logic        ev;
    logic [31:0] e0;
    logic [31:0] e1;
    if (with_reset) doReset();
    configure(tbl[idx].w0, tbl[idx].w1, tbl[idx].b0, tbl[idx].b1, tbl[idx].relu);
    for (int k = 0; k <= 28; k++) begin
      applyStimulus(k <= 16, k, 1'b0);
      ev = (k == 23) || (k == 24);
      if (k < 23) begin
        e0 = 32'd0;
        e1 = 32'd0;
      end else if (k == 23) begin
        e0 = tbl[idx].first0;
        e1 = tbl[idx].first1;
      end else begin
        e0 = tbl[idx].second0;
        e1 = tbl[idx].second1;
      end
      checkOutput($sformatf("vec%0d_edge%0d", idx, k), ev, e0, e1);
    end
  endtask

  initial begin
    logic        ev;
    logic [31:0] e0;
    logic [31:0] e1;
    int          sample;

    compared        = 0;
    mismatched      = 0;
    reset           = 1'b1;
    clear           = 1'b0;
    pixel_valid_in  = 1'b0;
    pixel_vector_in = '0;
    kernel          = '0;
    bias            = '0;
    relu_en         = 1'b0;

    //          w0     w1     b0            b1          relu  first0        first1       second0       second1
    tbl[0] = '{8'h01, 8'h02, 32'd0,        32'd0,      1'b0, 32'd480,      32'd960,     32'd544,      32'd1088};
    tbl[1] = '{8'h01, 8'h02, -32'sd600,    32'd0,      1'b0, -32'sd120,    32'd960,     -32'sd56,     32'd1088};
    tbl[2] = '{8'h01, 8'h02, -32'sd600,    32'd0,      1'b1, 32'd0,        32'd960,     32'd0,        32'd1088};
    tbl[3] = '{8'hFF, 8'h02, 32'd0,        32'd0,      1'b0, -32'sd480,    32'd960,     -32'sd544,    32'd1088};
    tbl[4] = '{8'hFF, 8'hFE, 32'd0,        32'd1000,   1'b1, 32'd0,        32'd40,      32'd0,        32'd0};
    tbl[5] = '{8'h01, 8'h02, 32'd0,        32'd100,    1'b1, 32'd480,      32'd1060,    32'd544,      32'd1188};

    for (int v = 0; v < 6; v++) begin
      runStream(v, 1'b1);
    end

    // Valid gap: samples 0..15, three idle cycles, then sample 16 on edge 19.
    doReset();
    configure(8'h01, 8'h02, 32'd0, 32'd0, 1'b0);
    for (int k = 0; k <= 30; k++) begin
      sample = (k <= 15) ? k : 16;
      applyStimulus((k <= 15) || (k == 19), sample, 1'b0);
      ev = (k == 23) || (k == 27);
      if (k < 23) begin
        e0 = 32'd0;
        e1 = 32'd0;
      end else if (k < 27) begin
        e0 = 32'd480;
        e1 = 32'd960;
      end else begin
        e0 = 32'd544;
        e1 = 32'd1088;
      end
      checkOutput($sformatf("gap_edge%0d", k), ev, e0, e1);
    end

    // Clear on edge 20 with a valid sample: in-flight results for samples
    // 15..19 vanish, sample 20 is dropped, and samples 21..36 refill.
    doReset();
    configure(8'h01, 8'h02, 32'd0, 32'd0, 1'b0);
    for (int k = 0; k <= 48; k++) begin
      applyStimulus(k <= 37, k, k == 20);
      ev = (k == 44) || (k == 45);
      if (k < 44) begin
        e0 = 32'd0;
        e1 = 32'd0;
      end else if (k == 44) begin
        e0 = 32'd1824;
        e1 = 32'd3648;
      end else begin
        e0 = 32'd1888;
        e1 = 32'd3776;
      end
      checkOutput($sformatf("clear_edge%0d", k), ev, e0, e1);
    end

    // Reset while results are in flight, then rerun the basic stream.
    doReset();
    configure(8'h01, 8'h02, 32'd0, 32'd0, 1'b0);
    for (int k = 0; k <= 24; k++) begin
      applyStimulus(1'b1, k, 1'b0);
    end
    checkOutput("mid_before_reset", 1'b1, 32'd544, 32'd1088);
    reset          = 1'b0;
    pixel_valid_in = 1'b0;
    #1;
    checkOutput("mid_reset_async", 1'b0, 32'd0, 32'd0);
    @(posedge clock);
    @(posedge clock);
    #2;
    reset = 1'b1;
    runStream(0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
